div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/rv_div_pkg.sv | 42 ++++
 rtl/div_unit_if.sv | 33 +++
 rtl/div_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rv_div_pkg.sv
// Shared types and constants for the iterative divider.
//   div_op_e    : RV32M divide opcodes (DIV, DIVU, REM, REMU)
//   div_state_e : divider control states
//   XLEN        : operand width
//   DIV_ITER    : quotient bits produced by the restoring loop
//   CNT_W       : iteration counter width (0..DIV_ITER inclusive)
package rv_div_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = 6;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Signed variants treat operands as two's complement.
    function automatic logic op_is_signed(div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Remainder variants return the remainder instead of the quotient.
    function automatic logic op_is_rem(div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Magnitude of v when it is to be read as signed; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(logic [XLEN-1:0] v, logic is_signed);
        return (is_signed && v[XLEN-1]) ? XLEN'(-v) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
//   start_i     : begin a division (sampled only while idle)
//   op_i        : operation select
//   operand_a_i : dividend
//   operand_b_i : divisor
//   flush_i     : abort any operation in progress
//   busy_o      : divider not idle
//   valid_o     : one-cycle pulse, result_o is fresh
//   result_o    : quotient or remainder
// master = requester (pipeline), slave = divider.
interface div_unit_if;
    import rv_div_pkg::*;

    logic            start_i;
    div_op_e         op_i;
    logic [XLEN-1:0] operand_a_i;
    logic [XLEN-1:0] operand_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, operand_a_i, operand_b_i, flush_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, operand_a_i, operand_b_i, flush_i,
        output busy_o, valid_o, result_o
    );

endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU.
// Restoring radix-2 loop, one quotient bit per clock, 33 cycles from the
// accepting edge to valid_o. Divide-by-zero and signed overflow complete on
// the accepting edge.
//   clk_i : clock, all state on the rising edge
//   rst_i : asynchronous active-high reset
//   bus   : div_unit_if.slave (start/op/operands/flush in, busy/valid/result out)
module div_unit
    import rv_div_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    div_unit_if.slave bus
);

    div_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] quot;      // holds the dividend, shifted out as quotient bits shift in
    logic [XLEN-1:0] rem;       // partial remainder
    logic [XLEN-1:0] result;
    logic            valid;
    logic            neg_q;
    logic            neg_r;
    logic            is_rem_q;

    logic            req_signed;
    logic            req_rem;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            overflow;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic            step_ok;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quot_next;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] final_res;

    // Request decode: operand magnitudes and fast-path detection.
    always_comb begin
        req_signed = op_is_signed(bus.op_i);
        req_rem    = op_is_rem(bus.op_i);
        mag_a      = magnitude(bus.operand_a_i, req_signed);
        mag_b      = magnitude(bus.operand_b_i, req_signed);
        div_zero   = (bus.operand_b_i == '0);
        overflow   = req_signed
                     && (bus.operand_a_i == 32'h8000_0000)
                     && (bus.operand_b_i == 32'hFFFF_FFFF);
    end

    // One restoring step: shift in the next dividend bit, try to subtract.
    // rem < divisor keeps rem_shift below 2^33, so diff[XLEN] is the borrow.
    always_comb begin
        rem_shift = {rem, quot[XLEN-1]};
        diff      = rem_shift - {1'b0, divisor};
        step_ok   = ~diff[XLEN];
        rem_next  = step_ok ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_next = {quot[XLEN-2:0], step_ok};
    end

    // Sign fixup of the finished magnitudes.
    always_comb begin
        q_fix     = neg_q ? XLEN'(-quot) : quot;
        r_fix     = neg_r ? XLEN'(-rem)  : rem;
        final_res = is_rem_q ? r_fix : q_fix;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
            result   <= '0;
            valid    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_rem_q <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (bus.flush_i) begin
                // Abort from any state; result keeps its last valid value.
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            is_rem_q <= req_rem;
                            neg_q    <= req_signed
                                        & (bus.operand_a_i[XLEN-1] ^ bus.operand_b_i[XLEN-1]);
                            neg_r    <= req_signed & bus.operand_a_i[XLEN-1];
                            cnt      <= '0;
                            if (div_zero) begin
                                result <= req_rem ? bus.operand_a_i : '1;
                                valid  <= 1'b1;
                                state  <= S_DONE;
                            end else if (overflow) begin
                                result <= req_rem ? '0 : 32'h8000_0000;
                                valid  <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                quot    <= mag_a;
                                divisor <= mag_b;
                                rem     <= '0;
                                state   <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        if (cnt == CNT_W'(DIV_ITER)) begin
                            result <= final_res;
                            valid  <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            rem  <= rem_next;
                            quot <= quot_next;
                            cnt  <= cnt + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy_o   = (state != S_IDLE);
    assign bus.valid_o  = valid;
    assign bus.result_o = result;

endmodule
